jtpang_vtiming: RTL and testbench
=================================

JTPANG_VTIMING -- requirements
Module: jtpang_vtiming

Interface
REQ-001 SHALL provide these parameters: CEN_N, 1, fractional clock-enable numerator (4 bits).
REQ-002 SHALL provide: CEN_M, 3, fractional clock-enable denominator (4 bits, CEN_M > CEN_N).
REQ-003 SHALL provide: HCNT_END, 511, last H count; HB_START, 459, HB_END, 75, H blank edges; HS_START, 495, HS_LEN, 32, H sync start and width.
REQ-004 SHALL provide: VCNT_END, 271, last V count; VB_START, 247, VB_END, 7, V blank edges; VS_START, 263, VS_LEN, 3, V sync start and width in lines.
REQ-005 SHALL provide: NIRQ, 2, number of raster-interrupt channels (1..4).
REQ-006 SHALL provide these ports: clk, in, 1, system clock (48 MHz); rst, in, 1, reset, asynchronous and active-high.
REQ-007 SHALL provide: pxl2_cen out 1, pixel x2 enable; pxl_cen out 1, pixel enable.
REQ-008 SHALL provide: h out 9, raw H count; v out 9, raw V count; hf out 9, flip-adjusted H; vf out 8, flip-adjusted V; flip in 1, screen flip.
REQ-009 SHALL provide: LHBL out 1, H blank active-low; LVBL out 1, V blank active-low; HS out 1, H sync; VS out 1, V sync.
REQ-010 SHALL provide: irq_line in 9*NIRQ, per-channel compare line; irq_en in NIRQ, channel enables; irq_ack in NIRQ, per-channel acknowledge pulses; irq_n out NIRQ, active-low interrupt requests.

Function
REQ-011 SHALL accumulate CEN_N each clk modulo CEN_M and pulse pxl2_cen for one clk on each wrap; pxl_cen SHALL pulse on every second pxl2_cen (8 MHz at the defaults).
REQ-012 SHALL increment h on pxl_cen, wrapping from HCNT_END to 0.
REQ-013 SHALL increment v when h wraps, wrapping from VCNT_END to 0.
REQ-014 SHALL clear LHBL on the pxl_cen where h becomes HB_START and set it where h becomes HB_END; the same rule SHALL apply to LVBL with VB_START and VB_END, evaluated at h wrap.
REQ-015 SHALL raise HS when h becomes HS_START and hold it for exactly HS_LEN pixels, including across the h wrap.
REQ-016 SHALL raise VS at the h wrap into line VS_START and hold it for exactly VS_LEN lines.
REQ-017 SHALL compute hf = h XOR {9{flip}} and vf = v[7:0] XOR {8{flip}} combinationally, with no added latency.
REQ-018 SHALL register every timing output so that it changes only on clk cycles where pxl_cen is high.
REQ-019 SHALL raise an event for channel k at the h wrap into line irq_line[k] when irq_en[k] is 1, and SHALL drive irq_n[k] low on the following clk.
REQ-020 SHALL leave irq_n[k] high when irq_en[k] is 0, and clearing irq_en[k] SHALL drive irq_n[k] high on the next clk.
REQ-021 SHALL give a new event priority when the event and irq_ack[k] occur in the same clk, so irq_n[k] stays low.
REQ-022 SHALL never raise an event for an irq_line value greater than VCNT_END; this is not an error.
REQ-023 SHALL keep the channels independent, so several may be low at the same time.

Reset
REQ-024 SHALL force the following while rst is high, independent of clk: h=0, v=0, cen accumulator=0, pxl_cen=0, pxl2_cen=0, LHBL=0, LVBL=0, HS=0, VS=0, irq_n all 1.
REQ-025 SHALL apply REQ-024 when rst is asserted mid-frame, and SHALL start the first pxl2_cen CEN_M/CEN_N clk after release, rounded up.

Configuration
REQ-026 SHALL compile in REQ-019 to REQ-021 latched interrupt behaviour when JTPANG_VTIMING_IRQACK_EN is defined: irq_n[k] stays low until irq_ack[k] arrives.
REQ-027 SHALL ignore irq_ack when JTPANG_VTIMING_IRQACK_EN is undefined: irq_n[k] is low for exactly one line (HCNT_END+1 pxl_cen) from the event, then returns high.

Verification
REQ-028 SHALL cover: defaults, run 300 clk -> pxl2_cen every 3 clk, pxl_cen every 6 clk, exactly 50 pxl_cen.
REQ-029 SHALL cover: defaults, a full frame -> exactly 272 lines of 512 pixels; LVBL low for lines 247..6; HS high for h 495..14, wrapping; VS high for lines 263..265.
REQ-030 SHALL cover: flip=1 at h=3, v=10 -> hf=508 and vf=245 in the same cycle.
REQ-031 SHALL cover: IRQACK_EN defined, irq_line[0]=100, irq_en=01 -> irq_n[0] low one clk after the wrap into line 100; still low at line 102; high one clk after an irq_ack[0] pulse; irq_n[1] stays 1 throughout.
REQ-032 SHALL cover: IRQACK_EN defined, irq_ack[0] pulsed in the same clk as the line-100 event -> irq_n[0] low.
REQ-033 SHALL cover: rst asserted at v=150, h=200 with irq_n[0] low -> all REQ-024 values immediately; after release, h counts from 0 and LHBL rises when h becomes 75.

Source files
------------

// File: rtl/jtpang_vtiming.sv
// rtl/jtpang_vtiming.sv - fractional pixel enable, H/V raster timing and raster interrupts
// Optional build macro: JTPANG_VTIMING_IRQACK_EN (interrupts stay low until irq_ack)
module jtpang_vtiming #(
  parameter logic [3:0] CEN_N    = 4'd1,
  parameter logic [3:0] CEN_M    = 4'd3,
  parameter logic [8:0] HCNT_END = 9'd511,
  parameter logic [8:0] HB_START = 9'd459,
  parameter logic [8:0] HB_END   = 9'd75,
  parameter logic [8:0] HS_START = 9'd495,
  parameter logic [8:0] HS_LEN   = 9'd32,
  parameter logic [8:0] VCNT_END = 9'd271,
  parameter logic [8:0] VB_START = 9'd247,
  parameter logic [8:0] VB_END   = 9'd7,
  parameter logic [8:0] VS_START = 9'd263,
  parameter logic [8:0] VS_LEN   = 9'd3,
  parameter int         NIRQ     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 pxl2_cen,
  output logic                 pxl_cen,
  output logic [8:0]           h,
  output logic [8:0]           v,
  output logic [8:0]           hf,
  output logic [7:0]           vf,
  input  logic                 flip,
  output logic                 LHBL,
  output logic                 LVBL,
  output logic                 HS,
  output logic                 VS,
  input  logic [9*NIRQ-1:0]    irq_line,
  input  logic [NIRQ-1:0]      irq_en,
  input  logic [NIRQ-1:0]      irq_ack,
  output logic [NIRQ-1:0]      irq_n
);

  // Sync pulses end a fixed distance after they start, wrapping around the count.
  localparam int HS_STOP_I = (int'(HS_START) + int'(HS_LEN)) % (int'(HCNT_END) + 1);
  localparam int VS_STOP_I = (int'(VS_START) + int'(VS_LEN)) % (int'(VCNT_END) + 1);
  localparam logic [8:0] HS_STOP = 9'(HS_STOP_I);
  localparam logic [8:0] VS_STOP = 9'(VS_STOP_I);

  logic [3:0]      acc_q, acc_d;
  logic [4:0]      acc_sum;
  logic            half_q, half_d;
  logic            pxl2_cen_q, pxl2_cen_d;
  logic            pxl_cen_q, pxl_cen_d;
  logic [8:0]      h_q, h_d, v_q, v_d, h_nxt, v_nxt;
  logic            h_end;
  logic            lhbl_q, lhbl_d, lvbl_q, lvbl_d;
  logic            hs_q, hs_d, vs_q, vs_d;
  logic            wrap_q, wrap_d;
  logic [NIRQ-1:0] evt_q, evt_d, irq_n_q, irq_n_d;

  // Fractional clock enable: pxl2 on every accumulator wrap, pxl on every other one.
  always_comb begin
    acc_sum    = {1'b0, acc_q} + {1'b0, CEN_N};
    pxl2_cen_d = (acc_sum >= {1'b0, CEN_M});
    acc_d      = pxl2_cen_d ? 4'(acc_sum - {1'b0, CEN_M}) : acc_sum[3:0];
    pxl_cen_d  = pxl2_cen_d & half_q;
    half_d     = half_q ^ pxl2_cen_d;
  end

  // Raster counters, blanking and sync; all move together with the pixel enable.
  always_comb begin
    h_end  = (h_q == HCNT_END);
    h_nxt  = h_end ? 9'd0 : h_q + 9'd1;
    v_nxt  = (v_q == VCNT_END) ? 9'd0 : v_q + 9'd1;
    h_d    = h_q;
    v_d    = v_q;
    lhbl_d = lhbl_q;
    lvbl_d = lvbl_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    wrap_d = 1'b0;
    if (pxl_cen_d) begin
      h_d = h_nxt;
      if (h_nxt == HB_START)      lhbl_d = 1'b0;
      else if (h_nxt == HB_END)   lhbl_d = 1'b1;
      if (h_nxt == HS_START)      hs_d = 1'b1;
      else if (h_nxt == HS_STOP)  hs_d = 1'b0;
      if (h_end) begin
        wrap_d = 1'b1;
        v_d    = v_nxt;
        if (v_nxt == VB_START)     lvbl_d = 1'b0;
        else if (v_nxt == VB_END)  lvbl_d = 1'b1;
        if (v_nxt == VS_START)     vs_d = 1'b1;
        else if (v_nxt == VS_STOP) vs_d = 1'b0;
      end
    end
  end

  // Raster interrupts: event on the wrap into the compare line, request one clk later.
  always_comb begin
    evt_d   = '0;
    irq_n_d = irq_n_q;
    for (int k = 0; k < NIRQ; k++) begin
      evt_d[k] = wrap_d & irq_en[k] & (v_nxt == irq_line[9*k +: 9]);
`ifdef JTPANG_VTIMING_IRQACK_EN
      if (!irq_en[k])       irq_n_d[k] = 1'b1;
      else if (evt_q[k])    irq_n_d[k] = 1'b0;
      else if (irq_ack[k])  irq_n_d[k] = 1'b1;
`else
      if (!irq_en[k])       irq_n_d[k] = 1'b1;
      else if (evt_q[k])    irq_n_d[k] = 1'b0;
      else if (wrap_q)      irq_n_d[k] = 1'b1;
`endif
    end
  end

`ifdef JTPANG_VTIMING_IRQACK_EN
  logic unused_wrap;
  assign unused_wrap = wrap_q;
`else
  logic unused_ack;
  assign unused_ack = ^irq_ack;
`endif

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      half_q     <= 1'b0;
      pxl2_cen_q <= 1'b0;
      pxl_cen_q  <= 1'b0;
      h_q        <= '0;
      v_q        <= '0;
      lhbl_q     <= 1'b0;
      lvbl_q     <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      wrap_q     <= 1'b0;
      evt_q      <= '0;
      irq_n_q    <= '1;
    end else begin
      acc_q      <= acc_d;
      half_q     <= half_d;
      pxl2_cen_q <= pxl2_cen_d;
      pxl_cen_q  <= pxl_cen_d;
      h_q        <= h_d;
      v_q        <= v_d;
      lhbl_q     <= lhbl_d;
      lvbl_q     <= lvbl_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      wrap_q     <= wrap_d;
      evt_q      <= evt_d;
      irq_n_q    <= irq_n_d;
    end
  end

  assign pxl2_cen = pxl2_cen_q;
  assign pxl_cen  = pxl_cen_q;
  assign h        = h_q;
  assign v        = v_q;
  assign hf       = h_q ^ {9{flip}};
  assign vf       = v_q[7:0] ^ {8{flip}};
  assign LHBL     = lhbl_q;
  assign LVBL     = lvbl_q;
  assign HS       = hs_q;
  assign VS       = vs_q;
  assign irq_n    = irq_n_q;

endmodule

// File: tb/tb_jtpang_vtiming.sv
// tb/tb_jtpang_vtiming.sv - scoreboard bench for jtpang_vtiming on a reduced raster
module tb_jtpang_vtiming;
  localparam int CN = 1, CM = 3;
  localparam int HE = 63, HBS = 50, HBE = 9, HSS = 59, HSL = 8;
  localparam int VE = 29, VBS = 22, VBE = 3, VSS = 25, VSL = 3;
  localparam int NI = 2;
  localparam int CPP = 2 * CM / CN;
  localparam int LINE_CLK = (HE + 1) * CPP;
`ifdef JTPANG_VTIMING_IRQACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk, rst, flip, pxl2_cen, pxl_cen, LHBL, LVBL, HS, VS;
  logic [8:0] h, v, hf;
  logic [7:0] vf;
  logic [9*NI-1:0] irq_line;
  logic [NI-1:0] irq_en, irq_ack, irq_n;

  jtpang_vtiming #(
    .CEN_N(4'(CN)), .CEN_M(4'(CM)),
    .HCNT_END(9'(HE)), .HB_START(9'(HBS)), .HB_END(9'(HBE)), .HS_START(9'(HSS)), .HS_LEN(9'(HSL)),
    .VCNT_END(9'(VE)), .VB_START(9'(VBS)), .VB_END(9'(VBE)), .VS_START(9'(VSS)), .VS_LEN(9'(VSL)),
    .NIRQ(NI)
  ) dut (
    .clk(clk), .rst(rst), .pxl2_cen(pxl2_cen), .pxl_cen(pxl_cen),
    .h(h), .v(v), .hf(hf), .vf(vf), .flip(flip),
    .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
    .irq_line(irq_line), .irq_en(irq_en), .irq_ack(irq_ack), .irq_n(irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int h; int v; bit lhbl; bit lvbl; bit hs; bit vs; } tim_t;
  typedef struct { bit p2; bit p1; logic [NI-1:0] irqn; } cyc_t;
  tim_t tq[$];
  cyc_t cq[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 50) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input int x, input int s, input int len, input int m);
    return ((x - s + m) % m) < len;
  endfunction

  // Reference model: positions derive from the clock count since reset release.
  bit ev_v[NI];
  int ev_k[NI];
  initial begin
    int mk, q, qp, p, hh, ll, vv, ln;
    bit p1, p2, low, en, ak;
    tim_t t;
    cyc_t c;
    mk = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mk = 0;
        for (int i = 0; i < NI; i++) ev_v[i] = 1'b0;
      end else begin
        mk++;
        q  = mk * CN / CM;
        qp = (mk - 1) * CN / CM;
        p2 = (q != qp);
        p1 = p2 && (q % 2 == 0);
        p  = q / 2;
        hh = p % (HE + 1);
        ll = p / (HE + 1);
        vv = ll % (VE + 1);
        if (p1) begin
          t.h    = hh;
          t.v    = vv;
          t.lhbl = !in_win(hh, HBS, (HBE - HBS + HE + 1) % (HE + 1), HE + 1);
          t.lvbl = !in_win(vv, VBS, (VBE - VBS + VE + 1) % (VE + 1), VE + 1);
          t.hs   = in_win(hh, HSS, HSL, HE + 1) && (p >= HSS);
          t.vs   = in_win(vv, VSS, VSL, VE + 1) && (ll >= VSS);
          tq.push_back(t);
        end
        c.p2 = p2;
        c.p1 = p1;
        for (int i = 0; i < NI; i++) begin
          en = irq_en[i];
          ak = irq_ack[i];
          ln = int'(irq_line[9*i +: 9]);
          if (!en) ev_v[i] = 1'b0;
          else if (ACK && ak && ev_v[i] && mk > ev_k[i] + 1) ev_v[i] = 1'b0;
          low = ev_v[i] && (mk >= ev_k[i] + 1) && (ACK || mk <= ev_k[i] + LINE_CLK);
          c.irqn[i] = !low;
          if (p1 && hh == 0 && en && vv == ln) begin
            ev_v[i] = 1'b1;
            ev_k[i] = mk;
          end
        end
        cq.push_back(c);
      end
    end
  end

  // Monitor: per-clock enables and interrupts, raster values on each pixel enable.
  initial begin
    cyc_t c;
    tim_t t;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (cq.size() == 0) begin
          tests++; fails++;
          $display("FAIL cyc_queue: DUT cycle with no expected entry (t=%0t)", $time);
        end else begin
          c = cq.pop_front();
          chk("pxl2_cen", int'(pxl2_cen), int'(c.p2));
          chk("pxl_cen", int'(pxl_cen), int'(c.p1));
          chk("irq_n", int'(irq_n), int'(c.irqn));
        end
        if (pxl_cen) begin
          if (tq.size() == 0) begin
            tests++; fails++;
            $display("FAIL tim_queue: pxl_cen with no expected pixel (t=%0t)", $time);
          end else begin
            t = tq.pop_front();
            chk("h", int'(h), t.h);
            chk("v", int'(v), t.v);
            chk("LHBL", int'(LHBL), int'(t.lhbl));
            chk("LVBL", int'(LVBL), int'(t.lvbl));
            chk("HS", int'(HS), int'(t.hs));
            chk("VS", int'(VS), int'(t.vs));
            chk("hf", int'(hf), t.h ^ (flip ? 511 : 0));
            chk("vf", int'(vf), (t.v % 256) ^ (flip ? 255 : 0));
          end
        end
      end
    end
  end

  task automatic wait_hv(input int hh, input int vv, input string name);
    int n = 0;
    while (!(int'(h) == hh && int'(v) == vv) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30000) begin
      tests++; fails++;
      $display("FAIL %s: timeout waiting for h=%0d v=%0d", name, hh, vv);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_h"}, int'(h), 0);
    chk({tag, "_v"}, int'(v), 0);
    chk({tag, "_pxl2_cen"}, int'(pxl2_cen), 0);
    chk({tag, "_pxl_cen"}, int'(pxl_cen), 0);
    chk({tag, "_LHBL"}, int'(LHBL), 0);
    chk({tag, "_LVBL"}, int'(LVBL), 0);
    chk({tag, "_HS"}, int'(HS), 0);
    chk({tag, "_VS"}, int'(VS), 0);
    chk({tag, "_irq_n"}, int'(irq_n), 3);
  endtask

  // Stimulus sequence.
  initial begin
    int n2, n1;
    rst = 1'b1; flip = 1'b0; irq_line = '0; irq_en = '0; irq_ack = '0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;

    n2 = 0; n1 = 0;
    repeat (300) begin
      @(posedge clk);
      #3;
      n2 += int'(pxl2_cen);
      n1 += int'(pxl_cen);
    end
    chk("pxl2_count_300", n2, 100);
    chk("pxl_count_300", n1, 50);
    @(negedge clk);

    irq_line = {9'(VE + 3), 9'd12};
    irq_en = 2'b01;
    wait_hv(5, 14, "line14");
    chk("irq0_line14", int'(irq_n[0]), ACK ? 0 : 1);
    chk("irq1_line14", int'(irq_n[1]), 1);
    irq_ack = 2'b01;
    @(negedge clk);
    irq_ack = 2'b00;
    @(negedge clk);
    chk("irq0_after_ack", int'(irq_n[0]), 1);

    wait_hv(0, 12, "evt12");
    irq_ack = 2'b01;
    @(negedge clk);
    irq_ack = 2'b00;
    chk("irq0_ack_same_clk", int'(irq_n[0]), 0);
    repeat (20) @(negedge clk);
    chk("irq0_held", int'(irq_n[0]), 0);
    irq_en = 2'b00;
    @(negedge clk);
    chk("irq0_disabled", int'(irq_n[0]), 1);

    irq_line = {9'd7, 9'd20};
    irq_en = 2'b11;
    repeat (12000) begin
      @(negedge clk);
      if ($urandom_range(511) == 0) irq_line = {9'($urandom_range(VE + 5)), 9'($urandom_range(VE + 5))};
      if ($urandom_range(31) == 0) irq_en = 2'($urandom);
      irq_ack = ($urandom_range(63) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(127) == 0) flip = ~flip;
    end

    irq_ack = 2'b00;
    flip = 1'b0;
    wait_hv(3, 10, "flip_pos");
    flip = 1'b1;
    #1;
    chk("hf_flip", int'(hf), 508);
    chk("vf_flip", int'(vf), 245);
    @(negedge clk);
    flip = 1'b0;

    irq_line = {9'd0, 9'd15};
    irq_en = 2'b01;
    wait_hv(20, 15, "rst_pos");
    chk("irq0_before_rst", int'(irq_n[0]), 0);
    #1;
    rst = 1'b1;
    cq.delete();
    tq.delete();
    #1;
    check_reset("rst_mid");
    repeat (4) @(negedge clk);
    rst = 1'b0;
    wait_hv(HBE - 1, 0, "hbe_m1");
    chk("LHBL_before_hbe", int'(LHBL), 0);
    wait_hv(HBE, 0, "hbe");
    chk("LHBL_at_hbe", int'(LHBL), 1);
    repeat (200) @(negedge clk);
    chk("tq_drained", tq.size(), 0);
    chk("cq_drained", cq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
